// File: rtl/tweet_pkg.sv
// tweet_pkg: shared constants, entry layout and state encoding for the tweet RAM controller
package tweet_pkg;
  localparam int DEPTH = 256;
  localparam int LIMIT = 160;
  localparam logic [7:0] BS_CODE = 8'h08;
  localparam int VALID_BIT = 15;
  localparam int CHAR_LSB = 0;
  localparam int CHAR_W = 8;
  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_PLAY_RD = 3'd3;
  localparam logic [2:0] S_PLAY_WAIT = 3'd4;
  localparam logic [2:0] S_PLAY_OUT = 3'd5;
endpackage

// File: rtl/tweet_ram_ctrl.sv
// tweet_ram_ctrl: arbitrates the single-port tweet RAM between char writer, playback reader and clear sweep
module tweet_ram_ctrl import tweet_pkg::*; #(
  parameter int DEPTH = tweet_pkg::DEPTH,
  parameter int LIMIT = tweet_pkg::LIMIT,
  parameter logic [7:0] BS_CODE = tweet_pkg::BS_CODE
) (
  input logic sysclk,
  input logic reset,
  input logic rx_valid,
  output logic rx_ready,
  input logic [7:0] rx_data,
  input logic play_start,
  input logic clr_req,
  output logic tx_valid,
  input logic tx_ready,
  output logic [7:0] tx_data,
  output logic play_done,
  output logic overflow,
  output logic busy,
  output logic full,
  output logic [7:0] count,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic ram_we,
  output logic [15:0] ram_wdata,
  input logic [15:0] ram_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] LIM = 8'(LIMIT);
  logic [2:0] st;
  logic [AW-1:0] idx;
  logic [7:0] rd_ptr;
  logic accept;
  logic unused_bits;
  assign accept = st == S_IDLE && rx_valid && rx_ready;
  assign unused_bits = ^ram_rdata[14:8];
  always_ff @(posedge sysclk or posedge reset)
    if (reset) begin
      st <= S_CLEAR;
      idx <= '0;
      rd_ptr <= '0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      rx_ready <= 1'b0;
      tx_valid <= 1'b0;
      tx_data <= '0;
      play_done <= 1'b0;
      overflow <= 1'b0;
      busy <= 1'b1;
      full <= 1'b0;
      count <= '0;
    end else begin
      play_done <= 1'b0;
      overflow <= 1'b0;
      ram_we <= 1'b0;
      if (clr_req && st != S_CLEAR) begin
        st <= S_CLEAR;
        idx <= '0;
        tx_valid <= 1'b0;
        rx_ready <= 1'b0;
        busy <= 1'b1;
      end else case (st)
        S_CLEAR: begin
          ram_we <= 1'b1;
          ram_addr <= idx;
          ram_wdata <= '0;
          idx <= idx + 1'b1;
          count <= '0;
          full <= 1'b0;
          if (idx == AW'(DEPTH - 1)) begin
            st <= S_IDLE;
            rx_ready <= 1'b1;
            busy <= 1'b0;
          end
        end
        S_IDLE: begin
          rx_ready <= !accept;
          if (accept) begin
            if (rx_data == BS_CODE) begin
              if (count != 8'd0) begin
                st <= S_WRITE;
                busy <= 1'b1;
                ram_we <= 1'b1;
                ram_addr <= AW'(count - 8'd1);
                ram_wdata <= '0;
                count <= count - 8'd1;
                full <= 1'b0;
              end
            end else if (count == LIM) overflow <= 1'b1;
            else begin
              st <= S_WRITE;
              busy <= 1'b1;
              ram_we <= 1'b1;
              ram_addr <= AW'(count);
              ram_wdata <= {1'b1, 7'b0, rx_data};
              count <= count + 8'd1;
              full <= count + 8'd1 == LIM;
            end
          end else if (play_start) begin
            if (count == 8'd0) play_done <= 1'b1;
            else begin
              st <= S_PLAY_RD;
              busy <= 1'b1;
              rx_ready <= 1'b0;
              rd_ptr <= '0;
              ram_addr <= '0;
            end
          end
        end
        S_WRITE: begin
          st <= S_IDLE;
          rx_ready <= 1'b1;
          busy <= 1'b0;
        end
        S_PLAY_RD: st <= S_PLAY_WAIT;
        S_PLAY_WAIT:
          if (!ram_rdata[VALID_BIT]) begin
            play_done <= 1'b1;
            st <= S_IDLE;
            rx_ready <= 1'b1;
            busy <= 1'b0;
          end else begin
            tx_data <= ram_rdata[CHAR_LSB +: CHAR_W];
            tx_valid <= 1'b1;
            st <= S_PLAY_OUT;
          end
        S_PLAY_OUT:
          if (tx_ready) begin
            tx_valid <= 1'b0;
            rd_ptr <= rd_ptr + 8'd1;
            if (rd_ptr + 8'd1 == count) begin
              play_done <= 1'b1;
              st <= S_IDLE;
              rx_ready <= 1'b1;
              busy <= 1'b0;
            end else begin
              st <= S_PLAY_RD;
              ram_addr <= AW'(rd_ptr + 8'd1);
            end
          end
        default: begin
          st <= S_CLEAR;
          idx <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_tweet_ram_ctrl.sv
// tb_tweet_ram_ctrl: directed checks of sweep, write/backspace, limit, playback and clear abort
module tb_tweet_ram_ctrl;
  logic sysclk = 1'b0;
  logic reset = 1'b1;
  logic rx_valid = 1'b0, rx_ready;
  logic [7:0] rx_data = '0;
  logic play_start = 1'b0, clr_req = 1'b0;
  logic tx_valid, tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic play_done, overflow, busy, full;
  logic [7:0] count;
  logic [7:0] ram_addr;
  logic ram_we;
  logic [15:0] ram_wdata, ram_rdata;
  logic [15:0] mem [256];
  int checks = 0, errors = 0;
  int done_cnt = 0, we_cnt = 0;

  tweet_ram_ctrl dut (
    .sysclk(sysclk), .reset(reset), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .play_start(play_start), .clr_req(clr_req), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .play_done(play_done), .overflow(overflow), .busy(busy), .full(full),
    .count(count), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    if (play_done) done_cnt++;
    if (ram_we) we_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    rx_valid = 1'b1;
    rx_data = c;
    while (!rx_ready && n < 400) begin @(negedge sysclk); n++; end
    chk("rx_accept_wait", n < 400, 1);
    @(negedge sysclk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 400) begin @(negedge sysclk); n++; end
    chk(tag, n < 400, 1);
  endtask

  task automatic recv(input logic [7:0] e, input int hold);
    int n = 0, bad = 0;
    while (!tx_valid && n < 50) begin @(negedge sysclk); n++; end
    chk("tx_valid_wait", n < 50, 1);
    repeat (hold) begin
      @(negedge sysclk);
      if (!tx_valid || tx_data !== e) bad++;
    end
    chk("tx_hold_stable", bad, 0);
    chk("tx_data", tx_data, e);
    tx_ready = 1'b1;
    @(negedge sysclk);
    tx_ready = 1'b0;
    chk("tx_valid_drop", tx_valid, 0);
  endtask

  initial begin
    int bad, d0, w0;
    repeat (2) @(negedge sysclk);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_busy", busy, 1);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge sysclk);
      if (!(ram_we === 1'b1 && ram_addr === 8'(i) && ram_wdata === 16'h0)) bad++;
    end
    chk("sweep_writes", bad, 0);
    chk("sweep_busy", busy, 0);
    chk("sweep_rx_ready", rx_ready, 1);
    chk("sweep_count", count, 0);
    // two chars then playback under backpressure
    send(8'h48);
    chk("w0_we", ram_we, 1);
    chk("w0_addr", ram_addr, 0);
    chk("w0_wdata", ram_wdata, 16'h8048);
    chk("w0_count", count, 1);
    send(8'h49);
    chk("w1_addr", ram_addr, 1);
    chk("w1_count", count, 2);
    @(negedge sysclk);
    chk("ram0", mem[0], 16'h8048);
    chk("ram1", mem[1], 16'h8049);
    d0 = done_cnt;
    play_start = 1'b1;
    @(negedge sysclk);
    play_start = 1'b0;
    chk("play_busy", busy, 1);
    chk("play_rx_ready", rx_ready, 0);
    recv(8'h48, 5);
    chk("play_no_early_done", done_cnt - d0, 0);
    recv(8'h49, 5);
    chk("play_done_pulse", play_done, 1);
    @(negedge sysclk);
    chk("play_done_once", done_cnt - d0, 1);
    chk("play_count_kept", count, 2);
    chk("play_idle", busy, 0);
    // backspace handling
    clr_req = 1'b1;
    @(negedge sysclk);
    clr_req = 1'b0;
    wait_idle("clr1_wait");
    chk("clr1_count", count, 0);
    send(8'h41);
    send(8'h42);
    chk("ab_count", count, 2);
    send(8'h08);
    chk("bs1_addr", ram_addr, 1);
    chk("bs1_wdata", ram_wdata, 0);
    chk("bs1_count", count, 1);
    @(negedge sysclk);
    chk("bs1_ram1", mem[1], 0);
    send(8'h08);
    chk("bs2_addr", ram_addr, 0);
    chk("bs2_count", count, 0);
    @(negedge sysclk);
    w0 = we_cnt;
    send(8'h08);
    chk("bs3_no_we", ram_we, 0);
    chk("bs3_count", count, 0);
    @(negedge sysclk);
    chk("bs3_no_write", we_cnt - w0, 0);
    d0 = done_cnt;
    play_start = 1'b1;
    @(negedge sysclk);
    play_start = 1'b0;
    chk("empty_play_done", play_done, 1);
    chk("empty_play_idle", busy, 0);
    @(negedge sysclk);
    chk("empty_play_once", done_cnt - d0, 1);
    // fill to the limit
    for (int i = 0; i < 160; i++) send(8'h30 + 8'(i % 10));
    chk("lim_count", count, 160);
    chk("lim_full", full, 1);
    @(negedge sysclk);
    chk("lim_ram159", mem[159], 16'h8039);
    w0 = we_cnt;
    send(8'h5a);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_no_we", ram_we, 0);
    @(negedge sysclk);
    chk("ovf_one_cycle", overflow, 0);
    chk("ovf_no_write", we_cnt - w0, 0);
    chk("ovf_ram160", mem[160], 0);
    chk("ovf_count", count, 160);
    chk("ovf_full", full, 1);
    // clear while stalled in playback output
    play_start = 1'b1;
    @(negedge sysclk);
    play_start = 1'b0;
    repeat (4) @(negedge sysclk);
    chk("abort_tx_valid_pre", tx_valid, 1);
    chk("abort_tx_data_pre", tx_data, 8'h30);
    d0 = done_cnt;
    w0 = we_cnt;
    clr_req = 1'b1;
    @(negedge sysclk);
    clr_req = 1'b0;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_busy", busy, 1);
    wait_idle("abort_wait");
    @(negedge sysclk);
    chk("abort_sweep_writes", we_cnt - w0, 256);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_count", count, 0);
    chk("abort_full", full, 0);
    chk("abort_ram0", mem[0], 0);
    // simultaneous clear, rx and play in IDLE
    d0 = done_cnt;
    rx_valid = 1'b1;
    rx_data = 8'h55;
    play_start = 1'b1;
    clr_req = 1'b1;
    @(negedge sysclk);
    play_start = 1'b0;
    clr_req = 1'b0;
    chk("tri_busy", busy, 1);
    chk("tri_rx_ready", rx_ready, 0);
    chk("tri_no_we", ram_we, 0);
    wait_idle("tri_wait");
    @(negedge sysclk);
    rx_valid = 1'b0;
    chk("tri_we", ram_we, 1);
    chk("tri_addr", ram_addr, 0);
    chk("tri_wdata", ram_wdata, 16'h8055);
    chk("tri_count", count, 1);
    repeat (6) @(negedge sysclk);
    chk("tri_play_lost", done_cnt - d0, 0);
    chk("tri_no_tx", tx_valid, 0);
    chk("tri_idle", busy, 0);
    // reset mid-sweep restarts from address 0
    clr_req = 1'b1;
    @(negedge sysclk);
    clr_req = 1'b0;
    repeat (20) @(negedge sysclk);
    reset = 1'b1;
    #1;
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_addr", ram_addr, 0);
    chk("mid_rst_busy", busy, 1);
    @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    chk("mid_rst_restart_we", ram_we, 1);
    chk("mid_rst_restart_addr", ram_addr, 0);
    wait_idle("mid_rst_wait");
    chk("mid_rst_count", count, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tweet_ram_ctrl.md
Name: tweet_ram_ctrl

Overview:
- Sequencer and arbiter for the single-port 256x16 tweet RAM.
- Shares the RAM among three requesters: the serial-receive char writer, the playback reader and the clear engine.
- Owns the write pointer (char count), read pointer, 160-char limit and backspace handling.
- Sits between the RX deserialiser, the RAM and the serial transmitter; entry format is bit15 = valid, bits[7:0] = char, all other bits 0.

Parameters:
DEPTH, 256, RAM words; address width is clog2(DEPTH).
LIMIT, 160, maximum stored chars (LIMIT <= DEPTH).
BS_CODE, 8'h08, char code treated as backspace.

Ports:
sysclk  in  1  system clock, all logic on posedge.
reset  in  1  asynchronous, active-high reset.
rx_valid  in  1  received char available; held until accepted.
rx_ready  out  1  controller accepts rx_data this cycle when rx_valid is also high.
rx_data  in  8  received char.
play_start  in  1  one-cycle pulse, begin playback.
clr_req  in  1  one-cycle pulse, wipe buffer.
tx_valid  out  1  tx_data valid for the serial transmitter.
tx_ready  in  1  transmitter takes tx_data when tx_valid is also high.
tx_data  out  8  char to transmit.
play_done  out  1  one-cycle pulse at end of playback.
overflow  out  1  one-cycle pulse when a char is dropped at LIMIT.
busy  out  1  high in every state except IDLE.
full  out  1  count == LIMIT.
count  out  8  stored char count.
ram_addr  out  8  RAM address.
ram_we  out  1  RAM write enable.
ram_wdata  out  16  RAM write data.
ram_rdata  in  16  RAM read data, synchronous read, 1-cycle latency.

Behaviour:
- All outputs are registered.
- Reset values: ram_we=0, ram_addr=0, ram_wdata=0, rx_ready=0, tx_valid=0, tx_data=0, play_done=0, overflow=0, busy=1, full=0, count=0, state=CLEAR, sweep index=0.
- States: CLEAR, IDLE, WRITE, PLAY_RD, PLAY_WAIT, PLAY_OUT.
- CLEAR:
  - ram_we=1, ram_wdata=0, ram_addr=0..DEPTH-1, one word per cycle, DEPTH cycles total.
  - Then enter IDLE with count=0. clr_req and play_start are ignored here.
- IDLE:
  - rx_ready=1, busy=0.
  - Priority: clr_req > rx handshake > play_start.
  - clr_req: go to CLEAR with index 0.
  - rx handshake, normal char, count<LIMIT: WRITE at addr=count with wdata={1'b1,7'b0,rx_data}; count++ on the WRITE cycle.
  - rx handshake, normal char, count==LIMIT: drop the char, pulse overflow, stay in IDLE.
  - rx handshake, rx_data==BS_CODE, count>0: WRITE at addr=count-1 with wdata=0; count-- on the WRITE cycle.
  - rx handshake, rx_data==BS_CODE, count==0: no-op; the char is consumed.
  - play_start with count==0: pulse play_done on the next cycle, stay in IDLE.
  - play_start with count>0: rd_ptr=0, go to PLAY_RD.
- rx_ready goes low on the cycle after acceptance and stays low in every non-IDLE state. Playback therefore stalls RX; the upstream holds rx_valid.
- WRITE: exactly one cycle with ram_we=1, then IDLE. rx_ready=0 during WRITE, so the next accept occurs no earlier than 2 cycles after the previous one.
- PLAY_RD: ram_addr=rd_ptr, ram_we=0, go to PLAY_WAIT.
- PLAY_WAIT: capture ram_rdata.
  - bit15==0 (defensive): pulse play_done, go to IDLE.
  - Otherwise tx_data=rdata[7:0], tx_valid=1, go to PLAY_OUT.
- PLAY_OUT:
  - Hold tx_valid and tx_data until tx_ready; on handshake tx_valid=0 and rd_ptr++.
  - If rd_ptr+1==count: pulse play_done, go to IDLE. Otherwise go to PLAY_RD.
  - Minimum 3 cycles per char.
- clr_req in WRITE, PLAY_RD, PLAY_WAIT or PLAY_OUT:
  - Abort; a WRITE in progress still completes its single write cycle.
  - tx_valid=0 on the next cycle; no play_done is issued; go to CLEAR.
- Playback never modifies count or RAM.
- Reset asserted mid-operation: immediate return to reset values. The CLEAR sweep restarts from 0 after release.
- full and count update on the same edge as the WRITE state.

Decomposition:
- Shared package tweet_pkg holds: state enum, entry layout constants (VALID_BIT=15, CHAR_LSB=0, CHAR_W=8), BS_CODE, LIMIT, DEPTH.
- No sub-module needed: a single FSM plus three counters (sweep index, count, rd_ptr).

Test Plan:
- Release reset -> 256 cycles of ram_we=1, wdata=0, addr 0..255, then busy=0, rx_ready=1, count=0.
- Write 0x48 then 0x49, then play_start -> RAM[0]=16'h8048, RAM[1]=16'h8049; tx sends 0x48 then 0x49 under tx_ready backpressure (hold 5 cycles); play_done pulses once; count stays 2.
- Write 'A','B', then 0x08 -> RAM[1]=0, count=1; next 0x08 -> count=0; third 0x08 -> no write, count=0.
- Write 161 chars -> count=160, full=1; 161st char raises overflow for 1 cycle, no ram_we, RAM[160]=0.
- clr_req while in PLAY_OUT with tx_ready=0 -> tx_valid low next cycle, no play_done, full sweep, count=0.
- rx_valid, play_start and clr_req in the same IDLE cycle -> CLEAR wins; rx char accepted after sweep; play_start lost.
